// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   Writeback-side producer for the register file write port. ALU and load
//   results are buffered in a small in-order FIFO. One entry per cycle is drained
//   into the register file, either the normal bank or the IRQ shadow bank.
//   Draining pauses while MEM/WB is frozen. Newest-entry forwarding is provided
//   for two decode read ports.
//
// Ports
//   CLK, RST                    clock (rising edge), async active-low reset
//   ALU_Valid/Rd/Data/IRQ       ALU result push request
//   LD_Valid/Rd/Data/IRQ        load result push request (older than ALU when both)
//   WBQ_Ready                   at least two free slots
//   MEM_WB_Freeze               hold the head this cycle
//   Reg_Write_Enable__EX_MEM    register file write strobe
//   RD_Write_Addr/Data          head entry destination / data
//   WB_Ctrl__IRQ                head entry bank select (1 = shadow)
//   RSx_Read_Addr, RSx_Dec_Ctrl__IRQ  forwarding lookup address / bank
//   RSx_Fwd_Hit, RSx_Fwd_Data   lookup hit and youngest matching data
//   WBQ_Count                   occupancy
//   WBQ_Overflow                sticky push-while-full error
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ALU_Valid,
  input  logic [AW-1:0]              ALU_Rd,
  input  logic [DW-1:0]              ALU_Data,
  input  logic                       ALU_IRQ,
  input  logic                       LD_Valid,
  input  logic [AW-1:0]              LD_Rd,
  input  logic [DW-1:0]              LD_Data,
  input  logic                       LD_IRQ,
  output logic                       WBQ_Ready,
  input  logic                       MEM_WB_Freeze,
  output logic                       Reg_Write_Enable__EX_MEM,
  output logic [AW-1:0]              RD_Write_Addr,
  output logic [DW-1:0]              RD_Write_Data,
  output logic                       WB_Ctrl__IRQ,
  input  logic [AW-1:0]              RS1_Read_Addr,
  input  logic [AW-1:0]              RS2_Read_Addr,
  input  logic                       RS1_Dec_Ctrl__IRQ,
  input  logic                       RS2_Dec_Ctrl__IRQ,
  output logic                       RS1_Fwd_Hit,
  output logic                       RS2_Fwd_Hit,
  output logic [DW-1:0]              RS1_Fwd_Data,
  output logic [DW-1:0]              RS2_Fwd_Data,
  output logic [$clog2(DEPTH):0]     WBQ_Count,
  output logic                       WBQ_Overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic          irq_mem  [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt1;
  logic [CW-1:0] count, free_slots;
  logic          overflow;

  logic          ld_req, alu_req, pop;
  logic          first_vld, second_vld, first_acc, second_acc, drop;
  logic [AW-1:0] first_rd;
  logic [DW-1:0] first_data;
  logic          first_irq;

  // Requests to register 0 are discarded before they compete for slots.
  assign ld_req  = LD_Valid  && (LD_Rd  != '0);
  assign alu_req = ALU_Valid && (ALU_Rd != '0);

  assign pop = (count != '0) && !MEM_WB_Freeze;

  // The load is always the older of two same-cycle results, so it takes the
  // first slot. A lone ALU result also takes the first slot.
  assign first_vld  = ld_req || alu_req;
  assign second_vld = ld_req && alu_req;
  assign first_rd   = ld_req ? LD_Rd   : ALU_Rd;
  assign first_data = ld_req ? LD_Data : ALU_Data;
  assign first_irq  = ld_req ? LD_IRQ  : ALU_IRQ;

  // A slot freed by this cycle's pop may be reused by this cycle's push.
  assign free_slots  = CW'(DEPTH) - count + CW'(pop);
  assign first_acc   = first_vld  && (free_slots >= CW'(1));
  assign second_acc  = second_vld && (free_slots >= CW'(2));
  assign drop        = (first_vld && !first_acc) || (second_vld && !second_acc);
  assign wr_ptr_nxt1 = wr_ptr + PW'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count + CW'(first_acc) + CW'(second_acc) - CW'(pop);
      wr_ptr   <= wr_ptr + PW'(first_acc) + PW'(second_acc);
      rd_ptr   <= rd_ptr + PW'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    if (first_acc) begin
      rd_mem[wr_ptr]   <= first_rd;
      data_mem[wr_ptr] <= first_data;
      irq_mem[wr_ptr]  <= first_irq;
    end
    if (second_acc) begin
      rd_mem[wr_ptr_nxt1]   <= ALU_Rd;
      data_mem[wr_ptr_nxt1] <= ALU_Data;
      irq_mem[wr_ptr_nxt1]  <= ALU_IRQ;
    end
  end

  assign Reg_Write_Enable__EX_MEM = pop;
  assign RD_Write_Addr            = rd_mem[rd_ptr];
  assign RD_Write_Data            = data_mem[rd_ptr];
  assign WB_Ctrl__IRQ             = irq_mem[rd_ptr];
  assign WBQ_Ready                = (count <= CW'(DEPTH - 2));
  assign WBQ_Count                = count;
  assign WBQ_Overflow             = overflow;

  // Walk stored entries oldest to youngest so the youngest match wins. The head
  // is included even while being written, since that write lands on the edge.
  logic [PW-1:0] idx;
  always_comb begin
    idx          = '0;
    RS1_Fwd_Hit  = 1'b0;
    RS2_Fwd_Hit  = 1'b0;
    RS1_Fwd_Data = '0;
    RS2_Fwd_Data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if ((RS1_Read_Addr != '0) && (rd_mem[idx] == RS1_Read_Addr) &&
            (irq_mem[idx] == RS1_Dec_Ctrl__IRQ)) begin
          RS1_Fwd_Hit  = 1'b1;
          RS1_Fwd_Data = data_mem[idx];
        end
        if ((RS2_Read_Addr != '0) && (rd_mem[idx] == RS2_Read_Addr) &&
            (irq_mem[idx] == RS2_Dec_Ctrl__IRQ)) begin
          RS2_Fwd_Hit  = 1'b1;
          RS2_Fwd_Data = data_mem[idx];
        end
      end
    end
  end

endmodule
